// File: rtl/sss_generator.sv
// NR secondary synchronisation signal generator: two m-sequence LFSRs streamed as 127 BPSK bits over AXI-stream.
// Optional IQ mapping of each bit is enabled by defining SSS_GENERATOR_IQ_EN.
module sss_generator #(
  parameter int                 OUT_DW = 32,
  parameter logic signed [15:0] AMP    = 16'sh2000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [8:0]        N_id_1_i,
  input  logic [1:0]        N_id_2_i,
  input  logic              start_i,
  output logic              idle_o,
  output logic              error_o,
  output logic [9:0]        N_id_o,
  output logic              m_axis_out_tdata,
  output logic [OUT_DW-1:0] m_axis_iq_tdata,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tlast
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CALC    = 2'd1,
    S_ADVANCE = 2'd2,
    S_STREAM  = 2'd3
  } state_t;

  localparam logic [6:0] LFSR_INIT = 7'b0000001;
  localparam logic [6:0] LAST_IDX  = 7'd126;

  // Bit k of each state vector holds x(i+k); bit 0 is the current tap.
  function automatic logic [6:0] f_x0_step(input logic [6:0] s);
    return {s[4] ^ s[0], s[6:1]};
  endfunction

  function automatic logic [6:0] f_x1_step(input logic [6:0] s);
    return {s[1] ^ s[0], s[6:1]};
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [8:0]  r_nid1;
  logic [1:0]  r_nid2;
  logic [9:0]  r_nid;
  logic [6:0]  r_m0;
  logic [6:0]  r_m1;
  logic [6:0]  r_step;
  logic [6:0]  r_cnt;
  logic [6:0]  r_x0;
  logic [6:0]  r_x1;
  logic        r_idle;
  logic        r_error;
  logic        r_tvalid;
  logic        r_tdata;
  logic        r_tlast;

  logic [6:0]  w_step_nxt;
  logic [6:0]  w_cnt_nxt;
  logic [6:0]  w_x0_nxt;
  logic [6:0]  w_x1_nxt;
  logic [6:0]  w_m0;
  logic [6:0]  w_m1;
  logic [6:0]  w_m0_base;
  logic [6:0]  w_max;
  logic [9:0]  w_nid;
  logic        w_legal;
  logic        w_hs;
  logic        w_bit_nxt;

  assign w_legal   = (N_id_1_i <= 9'd335) && (N_id_2_i != 2'd3);
  assign w_nid     = ({1'b0, N_id_1_i} << 1) + {1'b0, N_id_1_i} + {8'd0, N_id_2_i};
  assign w_hs      = r_tvalid & m_axis_out_tready;
  assign w_max     = (r_m0 > r_m1) ? r_m0 : r_m1;
  assign w_bit_nxt = ~(w_x0_nxt[0] ^ w_x1_nxt[0]);

  // Cyclic shifts from the latched IDs; N_id_1 / 112 is resolved by comparing against 112 and 224.
  always_comb begin
    w_m0_base = 7'd0;
    w_m1      = 7'd0;
    w_m0      = 7'd0;
    if (r_nid1 >= 9'd224) begin
      w_m0_base = 7'd30;
      w_m1      = 7'(r_nid1 - 9'd224);
    end else if (r_nid1 >= 9'd112) begin
      w_m0_base = 7'd15;
      w_m1      = 7'(r_nid1 - 9'd112);
    end else begin
      w_m0_base = 7'd0;
      w_m1      = r_nid1[6:0];
    end
    case (r_nid2)
      2'd0:    w_m0 = w_m0_base;
      2'd1:    w_m0 = w_m0_base + 7'd5;
      2'd2:    w_m0 = w_m0_base + 7'd10;
      default: w_m0 = w_m0_base;
    endcase
  end

  // Next-state, LFSR and counter update logic.
  always_comb begin
    w_state_nxt = r_state;
    w_x0_nxt    = r_x0;
    w_x1_nxt    = r_x1;
    w_step_nxt  = r_step;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start_i && w_legal) begin
          w_state_nxt = S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        w_x0_nxt    = LFSR_INIT;
        w_x1_nxt    = LFSR_INIT;
        w_step_nxt  = 7'd0;
        w_state_nxt = S_ADVANCE;
      end
      S_ADVANCE: begin
        // Each LFSR stops on its own shift; the state exits once the longer shift is done.
        if (r_step == w_max) begin
          w_cnt_nxt   = 7'd0;
          w_state_nxt = S_STREAM;
        end else begin
          if (r_step < r_m0) begin
            w_x0_nxt = f_x0_step(r_x0);
          end else begin
            w_x0_nxt = r_x0;
          end
          if (r_step < r_m1) begin
            w_x1_nxt = f_x1_step(r_x1);
          end else begin
            w_x1_nxt = r_x1;
          end
          w_step_nxt = r_step + 7'd1;
        end
      end
      S_STREAM: begin
        if (w_hs) begin
          w_x0_nxt = f_x0_step(r_x0);
          w_x1_nxt = f_x1_step(r_x1);
          if (r_cnt == LAST_IDX) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 7'd1;
          end
        end else begin
          w_state_nxt = S_STREAM;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; outputs track the next state so a stall holds them.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_nid1   <= 9'd0;
      r_nid2   <= 2'd0;
      r_nid    <= 10'd0;
      r_m0     <= 7'd0;
      r_m1     <= 7'd0;
      r_step   <= 7'd0;
      r_cnt    <= 7'd0;
      r_x0     <= LFSR_INIT;
      r_x1     <= LFSR_INIT;
      r_idle   <= 1'b1;
      r_error  <= 1'b0;
      r_tvalid <= 1'b0;
      r_tdata  <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x0    <= w_x0_nxt;
      r_x1    <= w_x1_nxt;
      if ((r_state == S_IDLE) && start_i && w_legal) begin
        r_nid1 <= N_id_1_i;
        r_nid2 <= N_id_2_i;
        r_nid  <= w_nid;
      end
      if (r_state == S_CALC) begin
        r_m0 <= w_m0;
        r_m1 <= w_m1;
      end
      r_error  <= (r_state == S_IDLE) && start_i && !w_legal;
      r_idle   <= (w_state_nxt == S_IDLE);
      r_tvalid <= (w_state_nxt == S_STREAM);
      r_tdata  <= (w_state_nxt == S_STREAM) ? w_bit_nxt : 1'b0;
      r_tlast  <= (w_state_nxt == S_STREAM) && (w_cnt_nxt == LAST_IDX);
    end
  end

  assign idle_o            = r_idle;
  assign error_o           = r_error;
  assign N_id_o            = r_nid;
  assign m_axis_out_tvalid = r_tvalid;
  assign m_axis_out_tdata  = r_tdata;
  assign m_axis_out_tlast  = r_tlast;

`ifdef SSS_GENERATOR_IQ_EN
  localparam int                      HALF    = OUT_DW / 2;
  localparam logic signed [HALF-1:0] AMP_POS = HALF'(AMP);
  localparam logic signed [HALF-1:0] AMP_NEG = -AMP_POS;

  logic [OUT_DW-1:0] r_iq;

  // BPSK to IQ: real half carries +/-AMP, imaginary half is zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_iq <= {OUT_DW{1'b0}};
    end else if (w_state_nxt == S_STREAM) begin
      r_iq <= {{(OUT_DW-HALF){1'b0}}, (w_bit_nxt ? AMP_POS : AMP_NEG)};
    end else begin
      r_iq <= {OUT_DW{1'b0}};
    end
  end

  assign m_axis_iq_tdata = r_iq;
`else
  assign m_axis_iq_tdata = OUT_DW'(AMP) & {OUT_DW{1'b0}};
`endif

endmodule

// File: tb/tb_sss_generator.sv
// Directed self-checking bench for sss_generator: a reference model of d(n) fills a scoreboard queue at each start.
module tb_sss_generator;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [8:0]  N_id_1_i = 9'd0;
  logic [1:0]  N_id_2_i = 2'd0;
  logic        start_i = 1'b0;
  logic        idle_o;
  logic        error_o;
  logic [9:0]  N_id_o;
  logic        tdata;
  logic [31:0] iq;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;

  int n_cmp  = 0;
  int n_fail = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  sss_generator dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .N_id_1_i          (N_id_1_i),
    .N_id_2_i          (N_id_2_i),
    .start_i           (start_i),
    .idle_o            (idle_o),
    .error_o           (error_o),
    .N_id_o            (N_id_o),
    .m_axis_out_tdata  (tdata),
    .m_axis_iq_tdata   (iq),
    .m_axis_out_tvalid (tvalid),
    .m_axis_out_tready (tready),
    .m_axis_out_tlast  (tlast)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] iq_exp(input bit b);
`ifdef SSS_GENERATOR_IQ_EN
    return b ? 32'h0000_2000 : 32'h0000_E000;
`else
    return 32'h0000_0000;
`endif
  endfunction

  // Reference: x0/x1 by their recurrences, then d(n) from the +/-1 product.
  task automatic build_model(input int nid1, input int nid2, output int lat);
    bit x0[127];
    bit x1[127];
    int m0;
    int m1;
    int a;
    int b;
    for (int i = 0; i < 127; i++) begin
      x0[i] = 1'b0;
      x1[i] = 1'b0;
    end
    x0[0] = 1'b1;
    x1[0] = 1'b1;
    for (int i = 0; i < 120; i++) begin
      x0[i+7] = x0[i+4] ^ x0[i];
      x1[i+7] = x1[i+1] ^ x1[i];
    end
    m0 = 15 * (nid1 / 112) + 5 * nid2;
    m1 = nid1 % 112;
    for (int n = 0; n < 127; n++) begin
      a = 1 - 2 * int'(x0[(n + m0) % 127]);
      b = 1 - 2 * int'(x1[(n + m1) % 127]);
      exp_q.push_back((a * b) == 1);
    end
    lat = ((m0 > m1) ? m0 : m1) + 2;
  endtask

  task automatic run_seq(input int nid1, input int nid2, input bit stall,
                         input bit mid_start, input int reset_at);
    int   lat;
    int   cnt;
    int   n;
    int   guard;
    bit   r;
    bit   e;
    bit   prev_stall;
    bit   pulsed;
    logic pd;
    logic pl;
    logic [31:0] piq;
    build_model(nid1, nid2, lat);
    N_id_1_i = 9'(nid1);
    N_id_2_i = 2'(nid2);
    tready   = 1'b1;
    start_i  = 1'b1;
    tick;
    start_i = 1'b0;
    cnt = 0;
    while (!tvalid && cnt < 400) begin
      tick;
      cnt++;
    end
    chk("latency", cnt, lat);
    chk("n_id", N_id_o, 32'(3 * nid1 + nid2));
    n = 0;
    guard = 0;
    prev_stall = 1'b0;
    pd = 1'b0;
    pl = 1'b0;
    piq = 32'h0;
    while (n < 127 && guard < 3000) begin
      if (n == reset_at) begin
        reset_i = 1'b1;
        tick;
        reset_i = 1'b0;
        chk("rst_idle", idle_o, 1);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_nid", N_id_o, 0);
        chk("rst_iq", iq, 0);
        tick;
        chk("rst_hold_tvalid", tvalid, 0);
        exp_q.delete();
        return;
      end
      r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      tready = r;
      pulsed = mid_start && (n == 50) && !prev_stall;
      if (pulsed) begin
        N_id_1_i = 9'd7;
        N_id_2_i = 2'd1;
        start_i  = 1'b1;
      end
      if (prev_stall) begin
        chk("stall_tdata", tdata, pd);
        chk("stall_tlast", tlast, pl);
        chk("stall_iq", iq, piq);
      end
      if (tvalid && r) begin
        e = exp_q.pop_front();
        chk("tdata", tdata, e);
        chk("tlast", tlast, n == 126);
        chk("iq", iq, iq_exp(e));
        if (nid1 == 0 && nid2 == 0 && n < 9) chk("first9", tdata, 1);
        n++;
      end
      prev_stall = tvalid && !r;
      pd  = tdata;
      pl  = tlast;
      piq = iq;
      tick;
      guard++;
      if (pulsed) begin
        start_i = 1'b0;
        chk("mid_start_err", error_o, 0);
        chk("mid_start_nid", N_id_o, 32'(3 * nid1 + nid2));
      end
    end
    chk("handshakes", n, 127);
    tready = 1'b1;
    chk("end_tvalid", tvalid, 0);
    chk("end_idle", idle_o, 1);
  endtask

  task automatic bad_start(input int nid1, input int nid2);
    N_id_1_i = 9'(nid1);
    N_id_2_i = 2'(nid2);
    start_i  = 1'b1;
    tick;
    start_i = 1'b0;
    chk("err_pulse", error_o, 1);
    chk("err_idle", idle_o, 1);
    chk("err_tvalid", tvalid, 0);
    tick;
    chk("err_once", error_o, 0);
    chk("err_idle2", idle_o, 1);
    chk("err_tvalid2", tvalid, 0);
  endtask

  initial begin
    reset_i = 1'b1;
    tick;
    tick;
    reset_i = 1'b0;
    chk("reset_idle", idle_o, 1);
    chk("reset_tvalid", tvalid, 0);
    chk("reset_tlast", tlast, 0);
    chk("reset_error", error_o, 0);
    chk("reset_nid", N_id_o, 0);
    chk("reset_tdata", tdata, 0);
    chk("reset_iq", iq, 0);

    run_seq(0, 0, 1'b0, 1'b0, -1);
    run_seq(112, 2, 1'b0, 1'b0, -1);
    run_seq(335, 1, 1'b0, 1'b1, -1);
    bad_start(400, 0);
    bad_start(10, 3);
    run_seq(5, 1, 1'b1, 1'b0, 60);
    run_seq(5, 1, 1'b1, 1'b0, -1);
    run_seq(200, 0, 1'b1, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sss_generator.md
SSS_GENERATOR -- requirements
Module: sss_generator

Interface
REQ-001 SHALL have parameter OUT_DW, default 32: IQ output width; real part in the low half, imag part in the high half.
REQ-002 SHALL have parameter AMP, default 16'h2000: signed magnitude of the real part of each IQ sample.
REQ-003 SHALL have port clk_i  in  1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset_i  in  1: synchronous, active-high reset.
REQ-005 SHALL have port N_id_1_i  in  9: cell ID group, legal range 0..335.
REQ-006 SHALL have port N_id_2_i  in  2: sector ID, legal range 0..2.
REQ-007 SHALL have port start_i  in  1: request to generate one SSS sequence.
REQ-008 SHALL have port idle_o  out  1: high when in IDLE, i.e. start_i can be accepted.
REQ-009 SHALL have port error_o  out  1: one-cycle pulse when a start is rejected for an illegal ID.
REQ-010 SHALL have port N_id_o  out  10: 3*N_id_1+N_id_2, latched at acceptance.
REQ-011 SHALL have port m_axis_out_tdata  out  1: BPSK bit; 1 = +1, 0 = -1, matching the SSS detector input convention.
REQ-012 SHALL have port m_axis_iq_tdata  out  OUT_DW: IQ sample of the same symbol.
REQ-013 SHALL have ports m_axis_out_tvalid  out  1, m_axis_out_tready  in  1 and m_axis_out_tlast  out  1: AXI-stream handshake.

Function
REQ-014 SHALL produce d(n)=[1-2x0((n+m0) mod 127)]*[1-2x1((n+m1) mod 127)] for n=0..126.
- m0=15*floor(N_id_1/112)+5*N_id_2; m1=N_id_1 mod 112.
REQ-015 SHALL generate x0 and x1 as 7-bit LFSRs with initial state x(0)=1, x(1..6)=0.
- x0(i+7)=x0(i+4) xor x0(i); x1(i+7)=x1(i+1) xor x1(i).
REQ-016 SHALL emit output bit = NOT(x0 xor x1) of the current LFSR taps.
REQ-017 SHALL implement states IDLE, CALC, ADVANCE, STREAM.
REQ-018 IDLE: on edge E0 with start_i=1 and legal IDs, SHALL latch the IDs, update N_id_o, and go to CALC.
REQ-019 IDLE: start_i with N_id_1_i>335 or N_id_2_i=3 SHALL be ignored; error_o pulses high for the cycle after E0; state remains IDLE.
REQ-020 CALC SHALL register m0 and m1 (no divider; compare against 112 and 224), reload both LFSRs, and go to ADVANCE.
REQ-021 ADVANCE SHALL step x0 while its step count < m0 and x1 while its step count < m1, then go to STREAM after max(m0,m1) cycles; it SHALL skip directly to STREAM when both are 0.
REQ-022 m_axis_out_tvalid SHALL rise after edge E0+max(m0,m1)+2.
REQ-023 STREAM: each edge with tvalid and tready both high SHALL advance both LFSRs one step and the sample counter by 1.
REQ-024 With tready low, tdata, iq_tdata and tlast SHALL stay stable.
REQ-025 tlast SHALL be high only on sample n=126; its handshake SHALL return the block to IDLE with tvalid low on the next cycle.
REQ-026 start_i outside IDLE SHALL be ignored without error_o.
REQ-027 Counters SHALL be 7-bit; the sample counter SHALL never wrap past 126.

Reset
REQ-028 reset_i SHALL force IDLE, idle_o=1, tvalid=0, tlast=0, error_o=0, N_id_o=0, tdata=0, iq_tdata=0 and LFSRs to their initial state on the next edge.
- This applies in any state, including mid-STREAM; no partial sequence resumes after reset.

Configuration
REQ-029 SHALL support the macro SSS_GENERATOR_IQ_EN.
- Defined: m_axis_iq_tdata real half = +AMP for bit 1 and -AMP for bit 0, sign-extended to OUT_DW/2; imag half = 0.
- Undefined: m_axis_iq_tdata tied to 0 and no IQ mapping logic synthesized; all other behaviour identical.

Verification
REQ-030 N_id_1=0, N_id_2=0, tready=1 -> tvalid rises after E0+2; first 9 bits all 1; 127 samples; tlast on the 127th; N_id_o=0.
REQ-031 N_id_1=112, N_id_2=2 (m0=25, m1=0) -> tvalid after E0+27; N_id_o=338; bits match the reference model from REQ-014.
REQ-032 N_id_1=335, N_id_2=1 (m0=35, m1=111) -> latency 113; all 127 bits match the model; start_i mid-stream is ignored.
REQ-033 N_id_1=400 or N_id_2=3 -> error_o pulses once, idle_o stays 1, tvalid stays 0.
REQ-034 Random tready backpressure -> data stable while stalled, exactly 127 handshakes; reset_i at sample 60 -> IDLE next cycle, then a fresh start gives a full correct sequence.
REQ-035 With SSS_GENERATOR_IQ_EN, AMP=16'h2000 -> real=16'h2000 for bit 1, 16'hE000 for bit 0, imag=0; without the macro, iq_tdata is always 0.
